// File: rtl/m_spi_pkg.sv
// Shared definitions for the button-triggered SPI frame sequencer:
// state encoding, frame constants and the frame byte lookup.
package m_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SEND,
    ST_LAG,
    ST_DONE
  } seq_state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         FRAME_LEN    = 14;

  // Byte idx of the frame: header, 12 payload bytes MSB first, then XOR of the payload.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [31:0] data,
                                            input logic [63:0] flt);
    logic [95:0] payload;
    logic [7:0]  csum;
    logic [7:0]  result;
    payload = {data, flt};
    csum    = 8'h00;
    for (int i = 0; i < 12; i++) csum = csum ^ payload[8*i +: 8];
    if (idx == 4'd0)
      result = FRAME_HEADER;
    else if (idx <= 4'd12)
      result = payload[8*(12 - int'(idx)) +: 8];
    else
      result = csum;
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; the output level
// only changes after DEBOUNCE_CYCLES consecutive samples disagree with it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_send_sequencer.sv
// Sends a 14-byte framed snapshot of i_data/i_float to an SPI byte engine
// each time the debounced send button is pressed.
module m_send_sequencer
  import m_spi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SS_LEAD         = 8,
  parameter int SS_LAG          = 8
) (
  input  logic        clk,
  input  logic        btn_reset,
  input  logic        btn_send,
  input  logic [31:0] i_data,
  input  logic [63:0] i_float,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_ss_req,
  output logic        o_busy,
  output logic        status,
  output logic [7:0]  o_frame_cnt
);

  seq_state_t  state;
  logic        level;
  logic        level_q;
  logic        trigger;
  logic [15:0] phase_cnt;
  logic [3:0]  byte_idx;
  logic [31:0] data_q;
  logic [63:0] float_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst_n (btn_reset),
    .btn   (btn_send),
    .level (level)
  );

  // Press is active-low, so a falling debounced level is the trigger.
  assign trigger = level_q & ~level;

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state       <= ST_IDLE;
      level_q     <= 1'b1;
      phase_cnt   <= '0;
      byte_idx    <= '0;
      data_q      <= '0;
      float_q     <= '0;
      o_tx_byte   <= 8'h00;
      o_tx_valid  <= 1'b0;
      o_ss_req    <= 1'b0;
      o_busy      <= 1'b0;
      status      <= 1'b0;
      o_frame_cnt <= 8'h00;
    end else begin
      level_q <= level;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            data_q    <= i_data;
            float_q   <= i_float;
            status    <= 1'b0;
            o_busy    <= 1'b1;
            o_ss_req  <= 1'b1;
            phase_cnt <= '0;
            state     <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (phase_cnt == 16'(SS_LEAD - 1)) begin
            o_tx_valid <= 1'b1;
            o_tx_byte  <= frame_byte(4'd0, data_q, float_q);
            byte_idx   <= 4'd0;
            state      <= ST_SEND;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        ST_SEND: begin
          if (o_tx_valid && i_tx_ready) begin
            if (byte_idx == 4'(FRAME_LEN - 1)) begin
              o_tx_valid <= 1'b0;
              o_tx_byte  <= 8'h00;
              phase_cnt  <= '0;
              state      <= ST_LAG;
            end else begin
              byte_idx  <= byte_idx + 4'd1;
              o_tx_byte <= frame_byte(byte_idx + 4'd1, data_q, float_q);
            end
          end
        end
        ST_LAG: begin
          if (phase_cnt == 16'(SS_LAG - 1)) begin
            o_ss_req <= 1'b0;
            state    <= ST_DONE;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          status      <= 1'b1;
          o_frame_cnt <= o_frame_cnt + 8'd1;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_send_sequencer.sv
// Self-checking bench for m_send_sequencer: directed scenarios plus randomized
// frames, checked against a byte-queue reference of the frame format.
module tb_m_send_sequencer;

  localparam int DEB  = 24;
  localparam int LEAD = 3;
  localparam int LAG  = 4;

  logic        clk = 1'b0;
  logic        btn_reset;
  logic        btn_send;
  logic [31:0] i_data;
  logic [63:0] i_float;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_ss_req;
  logic        o_busy;
  logic        status;
  logic [7:0]  o_frame_cnt;

  int          checks = 0;
  int          passes = 0;
  int          exp_cnt = 0;
  int          ready_mode = 0;
  int          ss_cycles = 0;
  int          valid_cycles = 0;
  bit          ss_seen = 1'b0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  m_send_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .SS_LEAD         (LEAD),
    .SS_LAG          (LAG)
  ) dut (
    .clk         (clk),
    .btn_reset   (btn_reset),
    .btn_send    (btn_send),
    .i_data      (i_data),
    .i_float     (i_float),
    .o_tx_byte   (o_tx_byte),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_ss_req    (o_ss_req),
    .o_busy      (o_busy),
    .status      (status),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      passes++;
  endtask

  // Byte engine model: ready pattern selected by ready_mode, changed just after each edge.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = ~i_tx_ready;
        2:       i_tx_ready = 1'($urandom_range(0, 1));
        default: i_tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: collects accepted bytes, checks that an unaccepted offer is held.
  always @(negedge clk) begin
    if (btn_reset) begin
      if (o_ss_req) begin
        ss_cycles++;
        ss_seen = 1'b1;
      end
      if (o_tx_valid) valid_cycles++;
      if (prev_valid && !prev_ready)
        checkOutput("hold", {55'd0, o_tx_valid, o_tx_byte}, {55'd0, 1'b1, prev_byte});
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_byte);
      prev_valid = o_tx_valid;
      prev_ready = i_tx_ready;
      prev_byte  = o_tx_byte;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int k = 0;
    while (o_busy !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, {63'd0, o_busy}, {63'd0, val});
  endtask

  task automatic build_expected(input logic [31:0] d, input logic [63:0] f);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
    for (int k = 7; k >= 0; k--) exp_q.push_back(f[8*k +: 8]);
    x = 8'h00;
    for (int k = 1; k <= 12; k++) x = x ^ exp_q[k];
    exp_q.push_back(x);
  endtask

  task automatic check_frame(input logic [31:0] d, input logic [63:0] f, input int mode);
    build_expected(d, f);
    checkOutput("frame_len", 64'(got_q.size()), 64'd14);
    for (int k = 0; k < 14; k++)
      if (k < got_q.size())
        checkOutput($sformatf("byte%0d", k), {56'd0, got_q[k]}, {56'd0, exp_q[k]});
    checkOutput("status", {63'd0, status}, 64'd1);
    checkOutput("frame_cnt", {56'd0, o_frame_cnt}, 64'(exp_cnt));
    checkOutput("ss_len", 64'(ss_cycles), 64'(LEAD + valid_cycles + LAG));
    if (mode == 0) checkOutput("send_cycles", 64'(valid_cycles), 64'd14);
  endtask

  task automatic clear_capture();
    got_q.delete();
    ss_cycles    = 0;
    valid_cycles = 0;
  endtask

  // One full press/frame/release; inputs are overwritten right after the trigger.
  task automatic applyStimulus(input logic [31:0] d, input logic [63:0] f,
                               input int mode, input logic [31:0] late_data);
    i_data     = d;
    i_float    = f;
    ready_mode = mode;
    clear_capture();
    btn_send = 1'b0;
    wait_busy(1'b1, DEB + 20, "busy_rise");
    i_data  = late_data;
    i_float = {$urandom, $urandom};
    wait_cycles(DEB + 10);
    btn_send = 1'b1;
    wait_busy(1'b0, 500, "busy_fall");
    wait_cycles(DEB + 10);
    exp_cnt = (exp_cnt + 1) % 256;
    check_frame(d, f, mode);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_reset = 1'b0;
    wait_cycles(3);
    btn_reset = 1'b1;
    exp_cnt   = 0;
    wait_cycles(DEB + 10);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] f;
    int          k;
    btn_reset = 1'b0;
    btn_send  = 1'b1;
    i_data    = '0;
    i_float   = '0;
    wait_cycles(3);
    checkOutput("rst_valid", {63'd0, o_tx_valid}, 64'd0);
    checkOutput("rst_byte", {56'd0, o_tx_byte}, 64'd0);
    checkOutput("rst_ss", {63'd0, o_ss_req}, 64'd0);
    checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("rst_status", {63'd0, status}, 64'd0);
    checkOutput("rst_cnt", {56'd0, o_frame_cnt}, 64'd0);
    btn_reset = 1'b1;
    wait_cycles(5);

    applyStimulus(32'h12345678, 64'h3FF0000000000000, 0, 32'hFFFFFFFF);

    ss_seen  = 1'b0;
    btn_send = 1'b0;
    wait_cycles(20);
    btn_send = 1'b1;
    wait_cycles(3 * DEB);
    checkOutput("glitch_ss", {63'd0, ss_seen}, 64'd0);
    checkOutput("glitch_cnt", {56'd0, o_frame_cnt}, 64'(exp_cnt));

    applyStimulus(32'h12345678, 64'h3FF0000000000000, 1, 32'hFFFFFFFF);

    // Reset right after the fifth accepted byte.
    ready_mode = 1;
    clear_capture();
    i_data   = $urandom;
    i_float  = {$urandom, $urandom};
    btn_send = 1'b0;
    k = 0;
    while (got_q.size() < 5 && k < DEB + 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_mid_reach", 64'(got_q.size() >= 5), 64'd1);
    @(posedge clk);
    #1;
    btn_reset = 1'b0;
    #1;
    checkOutput("rst_mid_ss", {63'd0, o_ss_req}, 64'd0);
    checkOutput("rst_mid_valid", {63'd0, o_tx_valid}, 64'd0);
    checkOutput("rst_mid_status", {63'd0, status}, 64'd0);
    checkOutput("rst_mid_cnt", {56'd0, o_frame_cnt}, 64'd0);
    btn_send = 1'b1;
    wait_cycles(3);
    btn_reset = 1'b1;
    exp_cnt   = 0;
    wait_cycles(DEB + 10);
    checkOutput("rst_mid_idle", {63'd0, o_busy}, 64'd0);
    applyStimulus($urandom, {$urandom, $urandom}, 0, $urandom);

    // Second press while the frame is stalled in SEND must be dropped.
    d = $urandom;
    f = {$urandom, $urandom};
    i_data     = d;
    i_float    = f;
    ready_mode = 3;
    clear_capture();
    btn_send = 1'b0;
    wait_busy(1'b1, DEB + 20, "busy_press_rise");
    wait_cycles(DEB + 10);
    btn_send = 1'b1;
    wait_cycles(DEB + 10);
    btn_send = 1'b0;
    wait_cycles(DEB + 10);
    btn_send = 1'b1;
    wait_cycles(DEB + 10);
    ready_mode = 0;
    wait_busy(1'b0, 500, "busy_press_fall");
    wait_cycles(3 * DEB);
    checkOutput("busy_press_idle", {63'd0, o_busy}, 64'd0);
    exp_cnt = (exp_cnt + 1) % 256;
    check_frame(d, f, 2);

    do_reset();
    for (int n = 0; n < 256; n++)
      applyStimulus($urandom, {$urandom, $urandom}, int'($urandom_range(0, 2)), $urandom);
    checkOutput("wrap", {56'd0, o_frame_cnt}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/m_send_sequencer.md
M_SEND_SEQUENCER -- requirements
Module: m_send_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of stable clk cycles that qualify a btn_send level (5 ms at 50 MHz).
REQ-002 SHALL have parameter SS_LEAD, default 8, meaning the clk cycles between o_ss_req assertion and the first byte offer.
REQ-003 SHALL have parameter SS_LAG, default 8, meaning the clk cycles between the last byte acceptance and o_ss_req deassertion.
REQ-004 SHALL have port clk, input, 1 bit: the single clock (50 MHz).
REQ-005 SHALL have port btn_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_send, input, 1 bit: raw active-low push button, asynchronous to clk.
REQ-007 SHALL have port i_data, input, 32 bits: integer payload.
REQ-008 SHALL have port i_float, input, 64 bits: IEEE-754 double payload.
REQ-009 SHALL have port o_tx_byte, output, 8 bits: byte offered to the SPI master byte engine.
REQ-010 SHALL have port o_tx_valid, output, 1 bit: o_tx_byte is valid.
REQ-011 SHALL have port i_tx_ready, input, 1 bit: the byte engine accepts the byte this cycle.
REQ-012 SHALL have port o_ss_req, output, 1 bit: frame active; the engine drives SS_N_MASTER low while this is high.
REQ-013 SHALL have port o_busy, output, 1 bit: the sequencer is not IDLE.
REQ-014 SHALL have port status, output, 1 bit: the last frame completed.
REQ-015 SHALL have port o_frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-016 SHALL pass btn_send through a 2-flop synchronizer, then a debouncer that updates the debounced level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-017 SHALL generate a one-cycle trigger on each debounced 1->0 transition; a held button yields exactly one trigger.
REQ-018 SHALL ignore a trigger that occurs while o_busy=1, with no queuing.
REQ-019 SHALL, on a trigger in IDLE, snapshot i_data and i_float into internal registers; later input changes SHALL NOT affect the frame.
REQ-020 SHALL send a frame of 14 bytes: 0xA5, i_data[31:24]..i_data[7:0], i_float[63:56]..i_float[7:0], then a checksum equal to the XOR of the 12 payload bytes.
REQ-021 SHALL use states IDLE -> LEAD (SS_LEAD cycles) -> SEND -> LAG (SS_LAG cycles) -> DONE (1 cycle) -> IDLE.
REQ-022 SHALL assert o_ss_req from entry to LEAD through the end of LAG.
REQ-023 SHALL, in SEND, hold o_tx_valid high with o_tx_byte stable until o_tx_valid&i_tx_ready, and transfer exactly one byte per such cycle.
REQ-024 SHALL present the next byte in the cycle after a transfer; back-to-back ready SHALL give 14 transfers in 14 cycles.
REQ-025 SHALL go from SEND to LAG on the cycle after the 14th transfer, with o_tx_valid low in LAG.
REQ-026 SHALL, with i_tx_ready held low, remain in SEND indefinitely without timeout.
REQ-027 SHALL clear status on a trigger accepted in IDLE and set it in DONE.
REQ-028 SHALL increment o_frame_cnt in DONE, wrapping from 255 to 0.
REQ-029 SHALL hold o_busy high in every state except IDLE.

Reset
REQ-030 SHALL, while btn_reset=0, asynchronously force IDLE, o_tx_valid=0, o_tx_byte=0x00, o_ss_req=0, o_busy=0, status=0, o_frame_cnt=0, debounced level=1, and debounce counter=0.
REQ-031 SHALL, on a reset asserted mid-frame, abandon the frame, deassert o_ss_req immediately, and never resume the frame.
REQ-032 SHALL NOT produce a trigger on release of btn_reset while btn_send is already low until the debouncer has qualified a new 1->0 transition.

Structure
REQ-033 SHALL place the state encoding, header value 0xA5 and frame length 14 in the shared package m_spi_pkg.
REQ-034 SHALL implement the synchronizer and debouncer as the sub-module btn_debounce (parameter DEBOUNCE_CYCLES), which is reusable for btn_reset conditioning.

Verification
REQ-035 SHALL verify: i_data=0x12345678, i_float=0x3FF0000000000000, press 6 ms, ready always 1 -> bytes A5 12 34 56 78 3F F0 00 00 00 00 00 00 C7, status=1, o_frame_cnt=1.
REQ-036 SHALL verify: a 20-cycle glitch low on btn_send -> no frame, o_ss_req stays 0.
REQ-037 SHALL verify: i_tx_ready toggling 1/0 each cycle -> same 14 bytes, each byte stable while unaccepted, o_ss_req high exactly LEAD+SEND+LAG cycles.
REQ-038 SHALL verify: i_data changed to 0xFFFFFFFF after the trigger -> the frame carries 0x12345678.
REQ-039 SHALL verify: reset asserted after the 5th byte -> o_ss_req=0 and o_tx_valid=0 within the same cycle, status=0, o_frame_cnt=0; the next press sends a full frame.
REQ-040 SHALL verify: 256 frames from counter 0 -> o_frame_cnt wraps to 0; a press during busy adds no extra frame.
